// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master/slave write link.
package i2c_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_DATA,
    M_DATA_ACK,
    M_STOP
  } m_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } s_state_e;

  localparam int TICKS_PER_BIT = 4;
  localparam logic [1:0] LAST_PHASE = 2'(TICKS_PER_BIT - 1);
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_slave.sv
// I2C write-only slave: bus edge/START/STOP detection, address match,
// ACK drive and received-byte register.
module i2c_slave
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] own_addr_i,
  output logic       sda_o,
  output logic [7:0] data_out_o,
  output logic       ack_o
);

  s_state_e   state_q, state_d;
  logic       scl_prev_q, sda_prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       sda_q, sda_d;
  logic [7:0] data_q, data_d;
  logic       ack_q, ack_d;

  logic rise, fall, start_det, stop_det;
  assign rise      = ~scl_prev_q & scl_i;
  assign fall      = scl_prev_q & ~scl_i;
  assign start_det = scl_prev_q & scl_i & sda_prev_q & ~sda_i;
  assign stop_det  = scl_prev_q & scl_i & ~sda_prev_q & sda_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sda_d   = sda_q;
    data_d  = data_q;
    ack_d   = ack_q;
    if (start_det) begin
      // A START restarts byte framing wherever we were.
      state_d = S_ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
      ack_d   = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (rise && cnt_q < 4'd8) begin
            sh_d  = {sh_q[6:0], sda_i};
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            if (state_q == S_DATA) begin
              sda_d   = 1'b0;
              data_d  = sh_q;
              ack_d   = 1'b1;
              state_d = S_DATA_ACK;
            end else if (sh_q[7:1] == own_addr_i && sh_q[0] == RW_WRITE) begin
              sda_d   = 1'b0;
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: if (fall) begin
          sda_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DATA;
        end
        S_DATA_ACK: if (fall) begin
          sda_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= S_IDLE;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      sda_q      <= 1'b1;
      data_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_prev_q <= scl_i;
      sda_prev_q <= sda_i;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sda_q      <= sda_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
    end
  end

  assign sda_o      = sda_q;
  assign data_out_o = data_q;
  assign ack_o      = ack_q;

endmodule

// File: rtl/i2c_master_slave.sv
// I2C write master plus on-chip slave joined by a wired-AND SCL/SDA bus.
// One address byte and one data byte per accepted start.
module i2c_master_slave
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [7:0] slave_addr,
  input  logic [7:0] own_addr,
  output logic       scl,
  output logic       sda,
  output logic [7:0] data_out,
  output logic       ack,
  output logic       done,
  output logic       nack,
  output logic       busy
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  m_state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          scl_m, sda_m, sda_s;
  logic          tick, scl_hi;

  logic unused_addr_msb;
  assign unused_addr_msb = slave_addr[7] ^ own_addr[7];

  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign scl_hi = (phase_q == 2'd1) || (phase_q == 2'd2);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    if (state_q != M_IDLE) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      M_IDLE: if (start) begin
        state_d = M_START;
        div_d   = '0;
        phase_d = '0;
        bit_d   = '0;
        shift_d = {slave_addr[6:0], RW_WRITE};
        data_d  = data_in;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
      end
      M_START: begin
        sda_m = (phase_q == 2'd0);
        if (tick) begin
          phase_d = (phase_q == 2'd1) ? 2'd0 : phase_q + 2'd1;
          if (phase_q == 2'd1) state_d = M_ADDR;
        end
      end
      M_ADDR, M_DATA: begin
        scl_m = scl_hi;
        sda_m = shift_q[7];
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == LAST_PHASE) begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == M_ADDR) ? M_ADDR_ACK : M_DATA_ACK;
          end
        end
      end
      M_ADDR_ACK, M_DATA_ACK: begin
        scl_m = scl_hi;
        if (tick) begin
          phase_d = phase_q + 2'd1;
          // Master releases SDA here, so the slave drive is the bus value.
          if (phase_q == 2'd2 && sda_s) nack_d = 1'b1;
          if (phase_q == LAST_PHASE) begin
            if (state_q == M_DATA_ACK || nack_q) begin
              state_d = M_STOP;
            end else begin
              state_d = M_DATA;
              shift_d = data_q;
            end
          end
        end
      end
      M_STOP: begin
        sda_m = (phase_q == 2'd1);
        if (tick) begin
          phase_d = (phase_q == 2'd1) ? 2'd0 : phase_q + 2'd1;
          if (phase_q == 2'd1) begin
            state_d = M_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= M_IDLE;
      div_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  i2c_slave u_slave (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .own_addr_i (own_addr[6:0]),
    .sda_o      (sda_s),
    .data_out_o (data_out),
    .ack_o      (ack)
  );

  assign scl  = scl_m;
  assign sda  = sda_m & sda_s;
  assign done = done_q;
  assign nack = done_q & nack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_i2c_master_slave.sv
// Randomized self-checking bench: bus decoder plus transaction-level model.
module tb_i2c_master_slave;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = '0, slave_addr = '0, own_addr = '0;
  logic       scl, sda, ack, done, nack, busy;
  logic [7:0] data_out;

  i2c_master_slave #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .slave_addr(slave_addr), .own_addr(own_addr), .scl(scl), .sda(sda),
    .data_out(data_out), .ack(ack), .done(done), .nack(nack), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Bus decoder: START/STOP events, bytes and ACK bits seen on the wires.
  logic [7:0] bq[$];
  logic       aq[$];
  int         start_cnt = 0, stop_cnt = 0;
  logic       pscl = 1'b1, psda = 1'b1;
  int         bitc = 0;
  logic [7:0] msh = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      bitc = 0;
    end else if (pscl && scl && psda && !sda) begin
      start_cnt++;
      bitc = 0;
    end else if (pscl && scl && !psda && sda) begin
      stop_cnt++;
      bitc = 0;
    end else if (!pscl && scl) begin
      if (bitc < 8) begin
        msh = {msh[6:0], sda};
        bitc++;
        if (bitc == 8) bq.push_back(msh);
      end else begin
        aq.push_back(!sda);
        bitc = 0;
      end
    end
    pscl = scl;
    psda = sda;
  end

  logic [7:0] m_data_out = '0;

  task automatic run_txn(input logic [7:0] d, input logic [7:0] sa, input logic [7:0] oa,
                         input bit disturb, input string name);
    int  b0 = bq.size(), a0 = aq.size(), s0 = start_cnt, p0 = stop_cnt;
    int  n = 0, exp_n;
    bit  seen = 0, match;
    match = (sa[6:0] == oa[6:0]);
    exp_n = (2 + 9 * TPB() + (match ? 9 * TPB() : 0) + 2) * CLK_DIV + 1;
    data_in = d; slave_addr = sa; own_addr = oa; start = 1'b1;
    while (n < 1000 && !seen) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
      end
      if (n == 12) begin
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL %s ack_clear_on_start: got %b required 0", name, ack); end
      end
      if (disturb && n == 50) begin start = 1'b1; data_in = ~d; slave_addr = sa ^ 8'h15; end
      if (disturb && n == 51) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no done after %0d cycles, required at %0d", name, n, exp_n);
      return;
    end
    if (match) m_data_out = d;
    if (n != exp_n) begin errors++; $display("FAIL %s done_cycle: got %0d required %0d", name, n, exp_n); end
    checks++;
    if (nack !== !match || busy !== 1'b0) begin
      errors++; $display("FAIL %s nack/busy: got nack=%b busy=%b required nack=%b busy=0", name, nack, busy, !match);
    end
    checks++;
    if (data_out !== m_data_out || ack !== match) begin
      errors++; $display("FAIL %s data_out/ack: got %h/%b required %h/%b", name, data_out, ack, m_data_out, match);
    end
    checks++;
    if (bq.size() - b0 != (match ? 2 : 1) || aq.size() - a0 != (match ? 2 : 1)) begin
      errors++; $display("FAIL %s bus_frames: got %0d bytes %0d acks required %0d", name, bq.size() - b0, aq.size() - a0, match ? 2 : 1);
    end else begin
      checks++;
      if (bq[b0] !== {sa[6:0], 1'b0} || aq[a0] !== match) begin
        errors++; $display("FAIL %s addr_byte: got %h ack=%b required %h ack=%b", name, bq[b0], aq[a0], {sa[6:0], 1'b0}, match);
      end
      if (match) begin
        checks++;
        if (bq[b0+1] !== d || aq[a0+1] !== 1'b1) begin
          errors++; $display("FAIL %s data_byte: got %h ack=%b required %h ack=1", name, bq[b0+1], aq[a0+1], d);
        end
      end
    end
    checks++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
      errors++; $display("FAIL %s start_stop_events: got %0d/%0d required 1/1", name, start_cnt - s0, stop_cnt - p0);
    end
  endtask

  function automatic int TPB();
    return 4;
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b1; data_in = 8'h77; slave_addr = 8'h10; own_addr = 8'h10;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    checks++;
    if ({scl, sda, data_out, ack, done, nack, busy} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values: scl=%b sda=%b data_out=%h ack=%b done=%b nack=%b busy=%b required 1 1 00 0 0 0 0",
                         scl, sda, data_out, ack, done, nack, busy);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_during_reset: busy=%b required 0", busy); end
    m_data_out = '0;
  endtask

  task automatic test_basic();
    run_txn(8'hA5, 8'h50, 8'h50, 0, "basic");
  endtask

  task automatic test_mismatch();
    run_txn(8'h5A, 8'h50, 8'h51, 0, "mismatch");
  endtask

  task automatic test_back_to_back();
    run_txn(8'h3C, 8'h2A, 8'hAA, 0, "b2b_first");
    run_txn(8'hFF, 8'h2A, 8'h2A, 0, "b2b_second");
  endtask

  task automatic test_start_while_busy();
    int extra = 0;
    run_txn(8'hC3, 8'h11, 8'h11, 1, "busy_start");
    repeat (350) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_start_single_done: got %0d active cycles required 0", extra); end
  endtask

  task automatic test_reset_mid();
    data_in = 8'h96; slave_addr = 8'h33; own_addr = 8'h33; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (200) @(posedge clk);
    #1; reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({scl, sda, busy, data_out, ack, done} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid: scl=%b sda=%b busy=%b data_out=%h ack=%b done=%b required 1 1 0 00 0 0",
                         scl, sda, busy, data_out, ack, done);
    end
    reset_n = 1'b0;
    m_data_out = '0;
    @(posedge clk); #1;
    run_txn(8'h69, 8'h33, 8'hB3, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d, sa, oa;
      d  = 8'($urandom);
      oa = 8'($urandom);
      sa = {1'($urandom), oa[6:0]};
      if ($urandom_range(0, 1) == 0) sa[$urandom_range(0, 6)] ^= 1'b1;
      run_txn(d, sa, oa, 0, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_slave.md
# i2c_master_slave

Single-clock I2C link containing an I2C master and an I2C slave on a shared, internally wired-AND SCL/SDA bus. The master performs one write transaction (address byte, then one data byte) per `start` request. The slave decodes its own 7-bit address, acknowledges, and presents the received byte. The block serves as a self-contained I2C write path and as the reference pairing for system-level bus checks.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per bus tick; one SCL bit = 4 ticks. Must be ≥2.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-high reset. Name kept from codebase; asserted = 1.
- start  in  1  one-cycle request to begin a write; ignored while busy.
- data_in  in  8  byte written by the master; sampled on accepted start.
- slave_addr  in  8  target address; [6:0] used, [7] ignored; sampled on accepted start.
- own_addr  in  8  slave's own address; [6:0] compared, [7] ignored.
- scl  out  1  resolved bus clock (master SCL, idle 1).
- sda  out  1  resolved bus data: AND of master and slave drive, released = 1.
- data_out  out  8  last data byte accepted by the slave.
- ack  out  1  slave acknowledged the data byte of the most recent transaction.
- done  out  1  one-cycle pulse at end of transaction.
- nack  out  1  with done: the address or data byte was not acknowledged.
- busy  out  1  master transaction in progress.

## Operation
- Reset values: scl=1, sda=1, data_out=0, ack=0, done=0, nack=0, busy=0. Master in IDLE, slave in IDLE.
- Master FSM states: IDLE → START → ADDR (8 bits) → ADDR_ACK → DATA (8 bits) → DATA_ACK → STOP → IDLE.
- START: SDA falls while SCL is high.
- First byte: {slave_addr[6:0], 1'b0} (write), MSB first.
- ADDR_ACK with SDA=1 (no ack): skip DATA and go to STOP with nack=1.
- STOP: SDA rises while SCL is high.
- done pulses for 1 cycle in the cycle after STOP finishes. busy clears in the same cycle.
- Slave edge detection: detects SCL rising/falling edges and START/STOP by comparing current and previous-cycle bus values.
- Slave on START: resets its bit counter, even in the middle of a byte.
- Slave on STOP: returns to IDLE.
- Slave sampling: samples SDA on each SCL rise.
- Slave addressing: after 8 bits, if byte[7:1]==own_addr[6:0] and byte[0]==0, pulls SDA low for the 9th bit; otherwise stays released and ignores the bus until the next START.
- Slave data phase: after the data byte, it drives ACK, loads data_out, and sets ack=1. A new START clears ack to 0.
- Read bit (byte[0]=1): not supported; the slave NACKs it.
- SDA changes only while SCL is low, except for START and STOP.
- reset_n mid-transaction: both FSMs return to IDLE next cycle and outputs take reset values. data_out is cleared.

## Timing
- Tick counter: wraps every CLK_DIV clocks.
- Data bit (4 ticks): tick0 SCL=0 and SDA updated; tick1 SCL=1; tick2 SCL=1, receiver samples at the rise; tick3 SCL=0.
- START: 2 ticks (SDA 1→0 while SCL=1). STOP: 2 ticks (SDA 0→1 while SCL=1).
- Full acknowledged transaction: 2 + 18×4 + 2 = 76 ticks, so done occurs at 76·CLK_DIV + 1 cycles after start (305 at default).
- start is accepted only in IDLE.
- start in the same cycle as reset_n: ignored.

## Structure
- Shared package i2c_pkg holds:
  - master state enum;
  - slave state enum;
  - constants TICKS_PER_BIT=4 and RW_WRITE=1'b0.
- Sub-module i2c_slave: address match, shift register, ACK drive, data_out/ack.
- Master FSM and wired-AND bus resolution sit in the top module.

## Test plan
- Reset, start=1 with data_in=8'hA5, slave_addr=8'h50, own_addr=8'h50.
  - Expect: bus bytes 8'hA0 then 8'hA5, both ACKed.
  - Expect: data_out=8'hA5, ack=1, done pulse with nack=0 at cycle 305.
- Address mismatch (own_addr=8'h51):
  - Expect: address byte NACKed, no data byte, done with nack=1.
  - Expect: data_out unchanged, ack=0.
- Back-to-back writes 8'h3C then 8'hFF:
  - Expect: data_out follows each.
  - Expect: ack cleared at the second START and set again.
- start pulsed while busy:
  - Expect: ignored; single done; data_in change mid-transfer has no effect.
- reset_n asserted mid-DATA:
  - Expect: next cycle scl=1, sda=1, busy=0, data_out=0.
  - Expect: a fresh transaction then completes normally.
- Protocol check throughout: SDA never changes while SCL=1, except at START/STOP.
